// File: rtl/dedekind_feeder_pkg.sv
// Shared types and constants for the two-lane full-permutation pipeline feeder
// and the result-side blocks that pair with it.
package dedekind_feeder_pkg;

    // One monotone Boolean function, stored as {upper64, lower64}
    typedef logic [127:0] mbf_t;

    // Each lane splits an MBF into a low and a high 64-bit half
    localparam int LANE_LOW_BITS = 64;

    // Lanes A and B travel side by side in every beat
    localparam int LANE_COUNT = 2;

    // Feeder sequencing: wait for a top, send its top beat, then stream bot pairs
    typedef enum logic [1:0] {
        IDLE,
        TOP,
        BOTS
    } feeder_state_t;

endpackage

// File: rtl/credit_counter.sv
// Up/down occupancy counter for beats in flight. Increments on a sent beat,
// decrements on a returned credit, never goes below zero, and reports whether
// another beat may be sent. The result collector reuses it.
module credit_counter #(
    parameter int MAX_COUNT = 64,
    parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             countUp,
    input  logic             countDown,
    output logic [WIDTH-1:0] count,
    output logic             belowMax
);

    // Simultaneous up and down cancel; a credit at zero is dropped. countUp is
    // only ever raised while belowMax holds, so the count cannot pass MAX_COUNT.
    always_ff @(posedge clock) begin
        if (rst) begin
            count <= '0;
        end else if (countUp && !countDown) begin
            count <= count + WIDTH'(1);
        end else if (countDown && !countUp && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign belowMax = (count < WIDTH'(MAX_COUNT));

endmodule

// File: rtl/bot_pair_feeder.sv
// Transmit-side driver for the full-permutation pipeline. Takes one top
// descriptor, sends it as a top beat, then packs the following bots two per
// beat into lanes A and B, padding an odd tail. Beats in flight are limited
// by credits returned from the result collector.
module bot_pair_feeder
    import dedekind_feeder_pkg::*;
#(
    parameter int           COUNT_BITS    = 32,
    parameter int           MAX_IN_FLIGHT = 64,
    parameter logic [127:0] PAD_BOT       = 128'h0
) (
    input  logic                                        clock,
    input  logic                                        rst,
    input  logic                                        topValid,
    output logic                                        topReady,
    input  logic [127:0]                                top,
    input  logic [COUNT_BITS-1:0]                       botCount,
    input  logic                                        botValid,
    output logic                                        botReady,
    input  logic [127:0]                                bot,
    output logic                                        ovalid,
    input  logic                                        oready,
    output logic                                        startNewTop,
    output logic [LANE_COUNT*LANE_LOW_BITS-1:0]         mbfLowers,
    output logic [LANE_COUNT*LANE_LOW_BITS-1:0]         mbfUppers,
    output logic                                        padB,
    input  logic                                        creditReturn,
    output logic [$clog2(MAX_IN_FLIGHT+1)-1:0]          inFlight,
    output logic [COUNT_BITS-1:0]                       topsSent,
    output logic [COUNT_BITS-1:0]                       beatsSent
);

    feeder_state_t         state, stateNext;
    mbf_t                  laneA, laneANext;
    mbf_t                  laneB, laneBNext;
    logic                  beatFull, beatFullNext;
    logic                  laneAFull, laneAFullNext;
    logic                  startNewTopNext;
    logic                  padBNext;
    logic [COUNT_BITS-1:0] remaining, remainingNext;
    logic                  belowMax;
    logic                  fire;

    // A full beat is only offered while the credit gate is open; the beat
    // register is held untouched until it actually fires.
    assign ovalid = beatFull && belowMax;
    assign fire   = ovalid && oready;

    assign mbfLowers = {laneA[LANE_LOW_BITS-1:0], laneB[LANE_LOW_BITS-1:0]};
    assign mbfUppers = {laneA[127:LANE_LOW_BITS], laneB[127:LANE_LOW_BITS]};

    credit_counter #(
        .MAX_COUNT (MAX_IN_FLIGHT),
        .WIDTH     ($clog2(MAX_IN_FLIGHT + 1))
    ) u_credits (
        .clock     (clock),
        .rst       (rst),
        .countUp   (fire),
        .countDown (creditReturn),
        .count     (inFlight),
        .belowMax  (belowMax)
    );

    // State and beat register; reset drops any latched top, partial beat and count
    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= IDLE;
            laneA       <= '0;
            laneB       <= '0;
            beatFull    <= 1'b0;
            laneAFull   <= 1'b0;
            startNewTop <= 1'b0;
            padB        <= 1'b0;
            remaining   <= '0;
        end else begin
            state       <= stateNext;
            laneA       <= laneANext;
            laneB       <= laneBNext;
            beatFull    <= beatFullNext;
            laneAFull   <= laneAFullNext;
            startNewTop <= startNewTopNext;
            padB        <= padBNext;
            remaining   <= remainingNext;
        end
    end

    // Next-state, handshake readies and beat assembly
    always_comb begin
        stateNext       = state;
        laneANext       = laneA;
        laneBNext       = laneB;
        beatFullNext    = beatFull;
        laneAFullNext   = laneAFull;
        startNewTopNext = startNewTop;
        padBNext        = padB;
        remainingNext   = remaining;
        topReady        = 1'b0;
        botReady        = 1'b0;

        case (state)
            IDLE: begin
                topReady = 1'b1;
                if (topValid) begin
                    laneANext       = top;
                    laneBNext       = '0;
                    startNewTopNext = 1'b1;
                    padBNext        = 1'b0;
                    beatFullNext    = 1'b1;
                    remainingNext   = botCount;
                    stateNext       = TOP;
                end
            end

            TOP: begin
                if (fire) begin
                    beatFullNext    = 1'b0;
                    startNewTopNext = 1'b0;
                    if (remaining == '0) begin
                        stateNext = IDLE;
                    end else begin
                        laneAFullNext = 1'b0;
                        stateNext     = BOTS;
                    end
                end
            end

            BOTS: begin
                // A bot may land in the same cycle the full beat leaves; it
                // then opens lane A of the next beat.
                botReady = (remaining != '0) && (!beatFull || fire);
                if (fire) begin
                    beatFullNext = 1'b0;
                    padBNext     = 1'b0;
                end
                if (botValid && botReady) begin
                    remainingNext = remaining - COUNT_BITS'(1);
                    if (!laneAFull) begin
                        laneANext = bot;
                        if (remaining == COUNT_BITS'(1)) begin
                            laneBNext    = PAD_BOT;
                            padBNext     = 1'b1;
                            beatFullNext = 1'b1;
                        end else begin
                            laneAFullNext = 1'b1;
                        end
                    end else begin
                        laneBNext     = bot;
                        laneAFullNext = 1'b0;
                        beatFullNext  = 1'b1;
                    end
                end else if (fire && (remaining == '0)) begin
                    stateNext = IDLE;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Statistics: top beats and bot beats actually handed to the pipeline
    always_ff @(posedge clock) begin
        if (rst) begin
            topsSent  <= '0;
            beatsSent <= '0;
        end else if (fire) begin
            if (startNewTop) begin
                topsSent <= topsSent + COUNT_BITS'(1);
            end else begin
                beatsSent <= beatsSent + COUNT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_bot_pair_feeder.sv
// Randomized bench for bot_pair_feeder. Each top and its bots are turned into
// an expected list of beats (top beat, then bots paired, odd tail padded);
// every fired beat is matched against that list, and credits, counters and
// stall behaviour are tracked by a small model alongside.
module tb_bot_pair_feeder;

    localparam int           CB   = 32;
    localparam int           MAXF = 2;
    localparam int           IFW  = $clog2(MAXF + 1);
    localparam logic [127:0] PAD  = 128'hA5A5_5A5A_C3C3_3C3C_0F0F_F0F0_9696_6969;

    logic          clock = 1'b0;
    logic          rst;
    logic          topValid;
    logic          topReady;
    logic [127:0]  top;
    logic [CB-1:0] botCount;
    logic          botValid;
    logic          botReady;
    logic [127:0]  bot;
    logic          ovalid;
    logic          oready;
    logic          startNewTop;
    logic [127:0]  mbfLowers;
    logic [127:0]  mbfUppers;
    logic          padB;
    logic          creditReturn;
    logic [IFW-1:0] inFlight;
    logic [CB-1:0] topsSent;
    logic [CB-1:0] beatsSent;

    bot_pair_feeder #(
        .COUNT_BITS    (CB),
        .MAX_IN_FLIGHT (MAXF),
        .PAD_BOT       (PAD)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .topValid     (topValid),
        .topReady     (topReady),
        .top          (top),
        .botCount     (botCount),
        .botValid     (botValid),
        .botReady     (botReady),
        .bot          (bot),
        .ovalid       (ovalid),
        .oready       (oready),
        .startNewTop  (startNewTop),
        .mbfLowers    (mbfLowers),
        .mbfUppers    (mbfUppers),
        .padB         (padB),
        .creditReturn (creditReturn),
        .inFlight     (inFlight),
        .topsSent     (topsSent),
        .beatsSent    (beatsSent)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         isTop;
        logic         isPad;
        logic [127:0] a;
        logic [127:0] b;
    } beat_t;

    beat_t        expQ[$];
    int           modelInFlight = 0;
    int           modelTops     = 0;
    int           modelBeats    = 0;
    logic         stallSeen     = 1'b0;
    logic [127:0] stallLow      = '0;
    logic [127:0] stallUp       = '0;
    int           checks        = 0;
    int           passes        = 0;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Scoreboard and credit model, sampled mid-cycle when inputs are settled
    always @(negedge clock) begin : monitor
        beat_t e;
        logic  fireNow;
        checkOutput("inFlight", 128'(inFlight), 128'(modelInFlight));
        checkOutput("topsSent", 128'(topsSent), 128'(modelTops));
        checkOutput("beatsSent", 128'(beatsSent), 128'(modelBeats));
        if (stallSeen) begin
            checkOutput("holdValid", 128'(ovalid), 128'(1));
            checkOutput("holdLowers", mbfLowers, stallLow);
            checkOutput("holdUppers", mbfUppers, stallUp);
        end
        if (ovalid) begin
            checkOutput("creditGate", 128'(modelInFlight < MAXF), 128'(1));
        end
        if (ovalid && !oready) begin
            checkOutput("stallBotReady", 128'(botReady), 128'(0));
        end
        if (rst) begin
            modelInFlight = 0;
            modelTops     = 0;
            modelBeats    = 0;
            stallSeen     = 1'b0;
            expQ.delete();
        end else begin
            fireNow = ovalid && oready;
            if (fireNow) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedBeat", 128'(ovalid), 128'(0));
                end else begin
                    e = expQ.pop_front();
                    checkOutput("beatStart", 128'(startNewTop), 128'(e.isTop));
                    checkOutput("beatPad", 128'(padB), 128'(e.isPad));
                    checkOutput("beatLowers", mbfLowers, {e.a[63:0], e.b[63:0]});
                    checkOutput("beatUppers", mbfUppers, {e.a[127:64], e.b[127:64]});
                    if (e.isTop) modelTops++;
                    else modelBeats++;
                end
            end
            stallSeen = ovalid && !oready;
            stallLow  = mbfLowers;
            stallUp   = mbfUppers;
            if (fireNow && !creditReturn) modelInFlight++;
            else if (creditReturn && !fireNow && modelInFlight > 0) modelInFlight--;
        end
    end

    // Offers one top and its n random bots; called and returns just after a rising edge
    task automatic applyStimulus(input logic [127:0] t, input int n, input int readyPct,
                                 input int creditPct, input int stopAfter);
        logic [127:0] bq[$];
        bit topPending = 1'b1;
        bit tookTop;
        bit tookBot;
        int idx = 0;
        int guard = 0;
        for (int i = 0; i < n; i++) bq.push_back({$urandom, $urandom, $urandom, $urandom});
        expQ.push_back('{1'b1, 1'b0, t, 128'h0});
        for (int i = 0; i < n; i += 2) begin
            if (i + 1 < n) expQ.push_back('{1'b0, 1'b0, bq[i], bq[i+1]});
            else expQ.push_back('{1'b0, 1'b1, bq[i], PAD});
        end
        top          = t;
        botCount     = CB'(n);
        topValid     = 1'b1;
        botValid     = 1'b0;
        oready       = ($urandom_range(0, 99) < readyPct);
        creditReturn = ($urandom_range(0, 99) < creditPct);
        while ((topPending || idx < n) && guard < 2000) begin
            @(negedge clock);
            tookTop = topValid && topReady;
            tookBot = botValid && botReady;
            if (topPending) checkOutput("botReadyBlocked", 128'(botReady), 128'(0));
            @(posedge clock);
            #1;
            guard++;
            if (tookTop) begin
                topPending = 1'b0;
                topValid   = 1'b0;
            end
            if (tookBot) idx++;
            if (stopAfter > 0 && idx >= stopAfter) break;
            botValid = !topPending && (idx < n) && ($urandom_range(0, 99) < 80);
            if (botValid) bot = bq[idx];
            oready       = ($urandom_range(0, 99) < readyPct);
            creditReturn = ($urandom_range(0, 99) < creditPct);
        end
        topValid = 1'b0;
        botValid = 1'b0;
        checkOutput("stimDone", 128'(guard < 2000), 128'(1));
    endtask

    // Lets every queued beat fire and every credit come back
    task automatic drain(input int creditPct);
        bit done = 1'b0;
        int guard = 0;
        oready = 1'b1;
        while (!done && guard < 1000) begin
            creditReturn = ($urandom_range(0, 99) < creditPct);
            @(negedge clock);
            checkOutput("botReadyDrain", 128'(botReady), 128'(0));
            #1;
            done = (expQ.size() == 0) && (modelInFlight == 0);
            @(posedge clock);
            #1;
            guard++;
        end
        creditReturn = 1'b0;
        checkOutput("drainDone", 128'(done), 128'(1));
    endtask

    initial begin
        rst          = 1'b1;
        topValid     = 1'b0;
        top          = '0;
        botCount     = '0;
        botValid     = 1'b0;
        bot          = '0;
        oready       = 1'b0;
        creditReturn = 1'b0;
        repeat (3) @(posedge clock);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clock);
        checkOutput("rstOvalid", 128'(ovalid), 128'(0));
        checkOutput("rstTopReady", 128'(topReady), 128'(1));
        checkOutput("rstBotReady", 128'(botReady), 128'(0));
        checkOutput("rstStart", 128'(startNewTop), 128'(0));
        checkOutput("rstPad", 128'(padB), 128'(0));
        checkOutput("rstLowers", mbfLowers, 128'h0);
        checkOutput("rstUppers", mbfUppers, 128'h0);
        @(posedge clock);
        #1;

        // Even count, pipeline always ready
        applyStimulus(128'h1, 4, 100, 60, 0);
        drain(60);
        @(negedge clock);
        checkOutput("fourTops", 128'(topsSent), 128'(1));
        checkOutput("fourBeats", 128'(beatsSent), 128'(2));
        checkOutput("fourIdle", 128'(topReady), 128'(1));
        @(posedge clock);
        #1;

        // Odd tail, then a top with no bots
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 3, 100, 60, 0);
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 0, 100, 60, 0);
        drain(60);

        // Heavy downstream backpressure
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 6, 35, 50, 0);
        drain(50);

        // Credit gate with no credits returned
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 4, 100, 0, 0);
        oready       = 1'b1;
        creditReturn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("gateClosed", 128'(ovalid), 128'(0));
        checkOutput("gateFull", 128'(inFlight), 128'(MAXF));
        @(posedge clock);
        #1 creditReturn = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("creditReopen", 128'(ovalid), 128'(1));
        checkOutput("reopenFlight", 128'(inFlight), 128'(MAXF - 1));
        @(posedge clock);
        #1 creditReturn = 1'b0;
        @(negedge clock);
        checkOutput("fireAndCredit", 128'(inFlight), 128'(MAXF - 1));
        checkOutput("allSent", 128'(ovalid), 128'(0));
        @(posedge clock);
        #1;
        drain(100);

        // Reset in the middle of a bot stream
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 4, 100, 50, 1);
        rst          = 1'b1;
        creditReturn = 1'b0;
        @(posedge clock);
        #1 rst = 1'b0;
        @(negedge clock);
        checkOutput("midRstOvalid", 128'(ovalid), 128'(0));
        checkOutput("midRstFlight", 128'(inFlight), 128'(0));
        checkOutput("midRstTopReady", 128'(topReady), 128'(1));
        @(posedge clock);
        #1;

        // Back-to-back tops after the reset
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 2, 100, 60, 0);
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1, 100, 60, 0);
        drain(60);
        @(negedge clock);
        checkOutput("b2bTops", 128'(topsSent), 128'(2));
        checkOutput("b2bBeats", 128'(beatsSent), 128'(2));
        @(posedge clock);
        #1;

        // Random mix of counts, readiness and credit rates
        for (int k = 0; k < 10; k++) begin
            applyStimulus({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 9),
                          $urandom_range(30, 100), $urandom_range(20, 80), 0);
        end
        drain(70);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bot_pair_feeder.md
Name: bot_pair_feeder

Overview:
- Transmit-side driver for the two-lane full-permutation pipeline input (startNewTop / mbfLowers / mbfUppers with valid/ready).
- Accepts one top descriptor (top MBF plus bot count) and a stream of single 128-bit bots.
- Emits one top beat, then packs the bots two per beat into lanes A and B, padding an odd tail.
- Limits beats in flight with a credit counter returned by the result collector; sits between the host bot buffer and the pipeline.

Parameters:
- COUNT_BITS, 32, width of the per-top bot count and the statistics counters
- MAX_IN_FLIGHT, 64, maximum beats sent but not yet credited back
- PAD_BOT, 128'h0, bot value placed in lane B for an odd tail

Ports:
- clock  in  1  system clock
- rst  in  1  synchronous active-high reset
- topValid  in  1  top descriptor valid
- topReady  out  1  descriptor accepted when topValid && topReady
- top  in  128  top MBF, as {upper64, lower64}
- botCount  in  COUNT_BITS  number of bots that follow this top
- botValid  in  1  bot stream valid
- botReady  out  1  bot accepted when botValid && botReady
- bot  in  128  bot MBF
- ovalid  out  1  beat valid toward pipeline
- oready  in  1  pipeline ready for input
- startNewTop  out  1  beat is a top beat
- mbfLowers  out  128  {A[63:0], B[63:0]}
- mbfUppers  out  128  {A[127:64], B[127:64]}
- padB  out  1  lane B carries PAD_BOT; valid with ovalid
- creditReturn  in  1  one pulse per result beat consumed downstream
- inFlight  out  $clog2(MAX_IN_FLIGHT+1)  beats outstanding
- topsSent  out  COUNT_BITS  top beats sent since reset
- beatsSent  out  COUNT_BITS  bot beats sent since reset

Behaviour:
- Reset: state IDLE; ovalid, startNewTop, padB, botReady = 0; topReady = 1; beat register = 0; inFlight, topsSent, beatsSent = 0. Reset mid-operation discards the latched top, the partial beat and the remaining count.
- fire = ovalid && oready. ovalid is gated: ovalid = beatFull && (inFlight < MAX_IN_FLIGHT).
- Outputs are held stable while ovalid && !oready. beatFull stays set while the credit gate is closed.
- IDLE:
  - topReady = 1.
  - On a top handshake: A <= top, B <= 0, startNewTop <= 1, beatFull <= 1, remaining <= botCount; go to TOP.
  - ovalid asserts the cycle after the handshake (latency 1).
- TOP:
  - topReady = 0 and botReady = 0.
  - On fire: topsSent++.
  - If remaining == 0, go to IDLE (the top beat is the only beat). Otherwise beatFull <= 0, laneA_full <= 0, go to BOTS.
- BOTS:
  - botReady = (remaining != 0) && (!beatFull || fire).
  - Each accepted bot decrements remaining and fills lane A if it is empty, else lane B, which sets beatFull.
  - If a bot is accepted into lane A and remaining becomes 0 (odd tail): B <= PAD_BOT, padB <= 1, beatFull <= 1.
  - A bot accepted in the same cycle as fire goes into lane A of the next beat.
  - On fire: beatsSent++, padB <= 0. If remaining == 0 and no bot was accepted this cycle, go to IDLE.
- Sustained rate: one bot per cycle in, one beat per two cycles out.
- inFlight update:
  - fire alone: +1.
  - creditReturn alone: −1.
  - Both in the same cycle: unchanged.
  - creditReturn at inFlight == 0 is ignored (saturates at 0).
  - Top beats and bot beats both consume credits.
- startNewTop = 0 on every bot beat.
- Counters wrap at 2^COUNT_BITS.
- botValid in IDLE or TOP is never accepted.
- topValid outside IDLE is never accepted.

Decomposition:
- Shared package dedekind_feeder_pkg:
  - typedef mbf_t (128-bit)
  - constants LANE_LOW_BITS = 64 and LANE_COUNT = 2
  - state enum {IDLE, TOP, BOTS}
- One natural sub-module: credit_counter (up/down counter that saturates at 0, with an inFlight < MAX comparison). It is reusable in the result collector.

Test Plan:
- Top T = 128'h…01 with botCount = 4; bots b0..b3; oready = 1 → beats, in order: {startNewTop=1, A=T}, {A=b0, B=b1}, {A=b2, B=b3}. Then topsSent = 1, beatsSent = 2, state IDLE.
- botCount = 3 → last beat has A = b2, B = PAD_BOT, padB = 1. botCount = 0 → top beat only, botReady never asserts.
- oready low for 5 cycles mid-stream → ovalid stays high, mbfLowers/mbfUppers unchanged, botReady low once the beat is full, no bot lost or duplicated.
- MAX_IN_FLIGHT = 2, no creditReturn → exactly 2 beats fire, then ovalid = 0. One creditReturn pulse → the next beat fires the following cycle. fire and creditReturn in the same cycle → inFlight unchanged.
- rst pulsed in BOTS after one of 4 bots was accepted → the next cycle shows ovalid = 0, inFlight = 0, topReady = 1. A new top is processed from the start.
- Back-to-back tops: botCount = 2, then 1 → the second top beat follows the first top's last beat with no bot beat in between. Total topsSent = 2, beatsSent = 2.
